adc_sif_tx: RTL and testbench



---
 rtl/adc_sif_tx.sv | 175 +++++++++++++++++
 tb/tb_adc_sif_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sif_tx.sv
// adc_sif_tx: ADC-style LVDS serializer. It emits one 2-bit pair per lane per CLKR cycle
// for ODDR primitives: a frame-clock lane plus CH_NUM data lanes, each sample sent MSB first.
module adc_sif_tx #(
  parameter int DATA_WIDTH = 12,
  parameter int CH_NUM     = 8
) (
  input  logic                         CLKR,
  input  logic                         RST,
  input  logic                         EN,
  input  logic [1:0]                   MODE,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [CH_NUM*DATA_WIDTH-1:0] IN_DATA,
  output logic [1:0]                   TX_FC,
  output logic [2*CH_NUM-1:0]          TX_DD,
  output logic                         FRAME_START,
  output logic                         UNDERRUN,
  output logic [15:0]                  UNDERRUN_CNT
);
  localparam int W  = CH_NUM * DATA_WIDTH;
  localparam int F  = DATA_WIDTH / 2;
  localparam int PW = (F > 1) ? $clog2(F) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(F - 1);
  localparam logic [PW-1:0] FC_PHASES  = PW'(F / 2);
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_RAMP   = 2'b01;
  localparam logic [1:0] MODE_FIXED  = 2'b10;

  if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_width_check
    $error("adc_sif_tx: DATA_WIDTH must be a non-zero multiple of 4");
  end

  typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;

  state_t                state_reg;
  logic [4:0]            init_cnt_reg;
  logic [PW-1:0]         phase_reg;
  logic [W-1:0]          shift_reg;
  logic [W-1:0]          last_word_reg;
  logic [W-1:0]          buf_data_reg;
  logic                  buf_full_reg;
  logic [DATA_WIDTH-1:0] ramp_reg;
  logic                  in_ready_reg;
  logic                  frame_start_reg;
  logic                  underrun_reg;
  logic [1:0]            tx_fc_reg;
  logic [2*CH_NUM-1:0]   tx_dd_reg;
  logic [15:0]           underrun_cnt_reg;

  logic [W-1:0]          ramp_word;
  logic [W-1:0]          fixed_word;
  logic [W-1:0]          frame_word;
  logic [W-1:0]          src_word;
  logic [W-1:0]          shift_next;
  logic [2*CH_NUM-1:0]   pairs_next;
  logic                  load;
  logic                  accept;
  logic                  take_buf;
  logic                  buf_full_next;
  logic [PW-1:0]         phase_inc;

  // Per-channel pattern sources and the 2-bit-per-cycle MSB-first shifter.
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    assign ramp_word[gi*DATA_WIDTH +: DATA_WIDTH] = ramp_reg + DATA_WIDTH'(gi);
    if ((gi % 2) == 0) begin : g_even
      assign fixed_word[gi*DATA_WIDTH +: DATA_WIDTH] = {(DATA_WIDTH/2){2'b10}};
    end else begin : g_odd
      assign fixed_word[gi*DATA_WIDTH +: DATA_WIDTH] = {(DATA_WIDTH/2){2'b01}};
    end
    assign pairs_next[2*gi +: 2] = src_word[gi*DATA_WIDTH + DATA_WIDTH - 2 +: 2];
    assign shift_next[gi*DATA_WIDTH +: DATA_WIDTH] =
      {src_word[gi*DATA_WIDTH +: DATA_WIDTH-2], 2'b00};
  end

  always_comb begin
    frame_word = '0;
    case (MODE)
      MODE_NORMAL: frame_word = buf_full_reg ? buf_data_reg : last_word_reg;
      MODE_RAMP:   frame_word = ramp_word;
      MODE_FIXED:  frame_word = fixed_word;
      default:     frame_word = '0;
    endcase
  end

  assign load   = EN && ((state_reg == IDLE) ||
                         (state_reg == RUN && phase_reg == LAST_PHASE));
  assign accept = IN_VALID && in_ready_reg;
  // Words offered outside normal mode are swallowed so the buffer never blocks the source.
  assign take_buf      = load && (MODE == MODE_NORMAL) && buf_full_reg;
  assign buf_full_next = (buf_full_reg && !take_buf) || (accept && MODE == MODE_NORMAL);
  assign src_word      = load ? frame_word : shift_reg;
  assign phase_inc     = phase_reg + PW'(1);

  always_ff @(posedge CLKR or posedge RST) begin
    if (RST) begin
      state_reg        <= INIT;
      init_cnt_reg     <= '0;
      phase_reg        <= '0;
      shift_reg        <= '0;
      last_word_reg    <= '0;
      buf_data_reg     <= '0;
      buf_full_reg     <= 1'b0;
      ramp_reg         <= '0;
      in_ready_reg     <= 1'b0;
      frame_start_reg  <= 1'b0;
      underrun_reg     <= 1'b0;
      tx_fc_reg        <= 2'b00;
      tx_dd_reg        <= '0;
      underrun_cnt_reg <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
      buf_full_reg    <= buf_full_next;
      in_ready_reg    <= !buf_full_next;
      if (accept && MODE == MODE_NORMAL) begin
        buf_data_reg <= IN_DATA;
      end
      if (load) begin
        state_reg       <= RUN;
        phase_reg       <= '0;
        tx_fc_reg       <= 2'b11;
        tx_dd_reg       <= pairs_next;
        shift_reg       <= shift_next;
        frame_start_reg <= 1'b1;
        last_word_reg   <= frame_word;
        if (MODE == MODE_RAMP) begin
          ramp_reg <= ramp_reg + DATA_WIDTH'(1);
        end
        if (MODE == MODE_NORMAL && !buf_full_reg) begin
          underrun_reg <= 1'b1;
          if (underrun_cnt_reg != 16'hFFFF) begin
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
          end
        end
      end else begin
        case (state_reg)
          INIT: begin
            tx_fc_reg    <= 2'b00;
            tx_dd_reg    <= '0;
            in_ready_reg <= (init_cnt_reg == 5'd31);
            init_cnt_reg <= init_cnt_reg + 5'd1;
            if (init_cnt_reg == 5'd31) begin
              state_reg <= IDLE;
            end
          end
          IDLE: begin
            tx_fc_reg <= 2'b00;
            tx_dd_reg <= '0;
          end
          RUN: begin
            if (phase_reg == LAST_PHASE) begin
              state_reg <= IDLE;
              tx_fc_reg <= 2'b00;
              tx_dd_reg <= '0;
            end else begin
              phase_reg <= phase_inc;
              tx_fc_reg <= (phase_inc < FC_PHASES) ? 2'b11 : 2'b00;
              tx_dd_reg <= pairs_next;
              shift_reg <= shift_next;
            end
          end
          default: state_reg <= INIT;
        endcase
      end
    end
  end

  assign IN_READY     = in_ready_reg;
  assign TX_FC        = tx_fc_reg;
  assign TX_DD        = tx_dd_reg;
  assign FRAME_START  = frame_start_reg;
  assign UNDERRUN     = underrun_reg;
  assign UNDERRUN_CNT = underrun_cnt_reg;

endmodule

// File: tb/tb_adc_sif_tx.sv
// tb_adc_sif_tx: directed checks of the ADC serializer: start-up, frame layout, buffer
// handshake, underrun accounting, ramp/fixed patterns, EN drop and asynchronous reset.
`timescale 1ns/1ps
module tb_adc_sif_tx;
  localparam int DW = 12;
  localparam int CH = 8;
  localparam int W  = CH * DW;
  localparam int F  = DW / 2;
  localparam logic [2*F-1:0] FC_EXP     = {{F{1'b1}}, {F{1'b0}}};
  localparam logic [F-1:0]   FS_EXP     = {1'b1, {(F-1){1'b0}}};
  localparam logic [W-1:0]   FIXED_WORD = {(CH/2){12'h555, 12'hAAA}};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic [1:0]      mode = 2'b11;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic [1:0]      tx_fc;
  logic [2*CH-1:0] tx_dd;
  logic            frame_start;
  logic            underrun;
  logic [15:0]     underrun_cnt;

  int n_test = 0;
  int n_fail = 0;

  logic [W-1:0]   got_word;
  logic [2*F-1:0] got_fc;
  logic [F-1:0]   got_fs;
  logic [F-1:0]   got_ur;
  logic [15:0]    got_cnt;
  int             got_wait;

  typedef struct {
    logic [1:0]   mode;
    logic         push;
    logic [W-1:0] data;
    logic [W-1:0] exp;
    logic         ur;
  } vec_t;
  vec_t vecs[6];
  logic [W-1:0] wq[5];

  adc_sif_tx #(.DATA_WIDTH(DW), .CH_NUM(CH)) dut (
    .CLKR(clk), .RST(rst), .EN(en), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .TX_FC(tx_fc), .TX_DD(tx_dd), .FRAME_START(frame_start),
    .UNDERRUN(underrun), .UNDERRUN_CNT(underrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ramp_word(input int r);
    logic [W-1:0] w;
    for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'(r + c);
    return w;
  endfunction

  function automatic logic [W-1:0] mk_word(input int seed);
    logic [W-1:0] w;
    for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'(seed * 37 + c * 291 + 5);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_fs();
    int guard = 0;
    do begin tick(); guard++; end while (!frame_start && guard < 40);
    if (!frame_start) begin
      n_test++; n_fail++;
      $display("FAIL wait_frame: frame_start=%0b required 1 within 40 cycles", frame_start);
    end
  endtask

  // Collect one frame; MODE/EN may be changed at phase 2 and MODE again at phase F-1.
  task automatic capture(input logic [1:0] p2_mode, input logic p2_en, input logic [1:0] end_mode);
    int guard = 0;
    got_word = '0; got_fc = '0; got_fs = '0; got_ur = '0;
    do begin tick(); guard++; end while (!frame_start && guard < 40);
    got_wait = guard;
    if (!frame_start) begin
      n_test++; n_fail++;
      $display("FAIL capture_start: frame_start=%0b required 1 within 40 cycles", frame_start);
    end
    for (int p = 0; p < F; p++) begin
      if (p > 0) tick();
      if (p == 0) got_cnt = underrun_cnt;
      for (int c = 0; c < CH; c++)
        got_word[c*DW +: DW] = {got_word[c*DW +: DW-2], tx_dd[2*c +: 2]};
      got_fc = {got_fc[2*F-3:0], tx_fc};
      got_fs = {got_fs[F-2:0], frame_start};
      got_ur = {got_ur[F-2:0], underrun};
      if (p == 2) begin mode = p2_mode; en = p2_en; end
      if (p == F-1) mode = end_mode;
    end
    $display("[TB] frame wait=%0d fc=%h fs=%b ur=%b cnt=%h ch0=%h ch3=%h ch7=%h",
             got_wait, got_fc, got_fs, got_ur, got_cnt,
             got_word[0 +: DW], got_word[3*DW +: DW], got_word[7*DW +: DW]);
  endtask

  task automatic chk_frame(input string name, input logic [W-1:0] exp_word, input logic exp_ur);
    chk({name, "_data"}, got_word, exp_word);
    chk({name, "_fc"}, got_fc, FC_EXP);
    chk({name, "_fs"}, got_fs, FS_EXP);
    chk({name, "_ur"}, got_ur, {exp_ur, {(F-1){1'b0}}});
  endtask

  task automatic push(input logic [W-1:0] d, input logic keep);
    int guard = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 40) begin tick(); guard++; end
    if (!in_ready) begin
      n_test++; n_fail++;
      $display("FAIL push_wait: in_ready=%0b required 1 within 40 cycles", in_ready);
    end else begin
      tick();
      $display("[TB] push %h mode=%b", d, mode);
      chk("ready_after_accept", in_ready, (mode == 2'b00) ? 1'b0 : 1'b1);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  // 32 quiet start-up cycles; IN_READY rises only on the last of them.
  task automatic init_check(input string name);
    int bad = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if ({tx_fc, tx_dd, frame_start, underrun} != '0) bad++;
      if (in_ready !== (i == 32)) bad++;
    end
    chk({name, "_quiet"}, bad, 0);
    capture(mode, 1'b1, mode);
    chk({name, "_latency"}, got_wait, 1);
    chk_frame(name, '0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 1'b1, {12'h3F0, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111, 12'hA5C},
                {12'h3F0, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111, 12'hA5C}, 1'b0};
    vecs[1] = '{2'b10, 1'b1, {CH{12'h123}}, FIXED_WORD, 1'b0};
    vecs[2] = '{2'b11, 1'b0, '0, '0, 1'b0};
    vecs[3] = '{2'b01, 1'b0, '0, ramp_word(0), 1'b0};
    vecs[4] = '{2'b01, 1'b1, {CH{12'hFFF}}, ramp_word(1), 1'b0};
    vecs[5] = '{2'b00, 1'b1, {12'h0F1, 12'h1E2, 12'h2D3, 12'h3C4, 12'h4B5, 12'h5A6, 12'h697, 12'h788},
                {12'h0F1, 12'h1E2, 12'h2D3, 12'h3C4, 12'h4B5, 12'h5A6, 12'h697, 12'h788}, 1'b0};
    for (int n = 0; n < 5; n++) wq[n] = mk_word(n + 1);

    // Reset state and start-up.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, tx_fc, tx_dd, frame_start, underrun, underrun_cnt}, '0);
    @(negedge clk) rst = 1'b0;
    init_check("init");
    capture(2'b11, 1'b1, 2'b11);
    chk("zero_backtoback", got_wait, 1);
    chk_frame("zero", '0, 1'b0);

    // Table vectors, each separated by an all-zero filler frame.
    for (int i = 0; i < 6; i++) begin
      wait_fs();
      mode = vecs[i].mode;
      if (vecs[i].push) push(vecs[i].data, 1'b0);
      capture(vecs[i].mode, 1'b1, 2'b11);
      chk_frame($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ur);
    end

    // Streaming source with IN_VALID held: every word once, in order.
    wait_fs();
    mode = 2'b00;
    fork
      begin
        for (int n = 0; n < 5; n++) push(wq[n], (n != 4));
      end
      begin
        for (int n = 0; n < 5; n++) begin
          capture(2'b00, 1'b1, (n == 4) ? 2'b11 : 2'b00);
          chk_frame($sformatf("stream%0d", n), wq[n], 1'b0);
        end
      end
    join

    // Starved source: last word repeats, count saturates.
    wait_fs();
    mode = 2'b00;
    push(wq[2], 1'b0);
    capture(2'b00, 1'b1, 2'b00);
    chk_frame("starve_first", wq[2], 1'b0);
    chk("cnt_before_underrun", got_cnt, 16'd0);
    for (int n = 1; n <= 3; n++) begin
      capture(2'b00, 1'b1, 2'b00);
      chk_frame($sformatf("underrun%0d", n), wq[2], 1'b1);
      chk($sformatf("underrun_cnt%0d", n), got_cnt, 16'(n));
    end
    force dut.underrun_cnt_reg = 16'hFFFE;
    #1;
    release dut.underrun_cnt_reg;
    capture(2'b00, 1'b1, 2'b00);
    chk("cnt_reach_max", got_cnt, 16'hFFFF);
    capture(2'b00, 1'b1, 2'b11);
    chk("cnt_saturate", got_cnt, 16'hFFFF);
    chk_frame("underrun_sat", wq[2], 1'b1);

    // Ramp frames, wrap, and a MODE change that waits for the frame boundary.
    wait_fs();
    mode = 2'b01;
    for (int n = 0; n < 3; n++) begin
      capture(2'b01, 1'b1, 2'b01);
      chk_frame($sformatf("ramp%0d", n), ramp_word(n + 2), 1'b0);
      chk($sformatf("ramp%0d_ch3", n), got_word[3*DW +: DW], DW'(n + 2 + 3));
    end
    force dut.ramp_reg = 12'hFFA;
    #1;
    release dut.ramp_reg;
    capture(2'b10, 1'b1, 2'b10);
    chk_frame("ramp_wrap", ramp_word(12'hFFA), 1'b0);
    chk("ramp_wrap_ch7", got_word[7*DW +: DW], 12'h001);
    capture(2'b10, 1'b1, 2'b11);
    chk("fixed_after_ramp_wait", got_wait, 1);
    chk_frame("fixed_after_ramp", FIXED_WORD, 1'b0);

    // EN dropped mid-frame: frame completes, then silence.
    wait_fs();
    mode = 2'b10;
    capture(2'b10, 1'b0, 2'b10);
    chk_frame("en_drop", FIXED_WORD, 1'b0);
    begin
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if ({tx_fc, tx_dd, frame_start} != '0) bad++;
      end
      chk("idle_quiet", bad, 0);
    end
    en = 1'b1;
    capture(2'b10, 1'b1, 2'b10);
    chk("restart_latency", got_wait, 1);
    chk_frame("restart", FIXED_WORD, 1'b0);

    // Asynchronous reset at phase 3.
    wait_fs();
    repeat (3) tick();
    chk("cnt_before_reset", underrun_cnt, 16'hFFFF);
    chk("dd_before_reset", tx_dd, FIXED_WORD[DW-2 +: 2] == 2'b10 ? {(CH/2){2'b01, 2'b10}} : '0);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {in_ready, tx_fc, tx_dd, frame_start, underrun, underrun_cnt}, '0);
    tick();
    tick();
    mode = 2'b11;
    en = 1'b1;
    @(negedge clk) rst = 1'b0;
    init_check("reinit");

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
